bus_router: RTL and testbench

- Registered bus stage between the criscv CPU memory port and its two targets: the mmu (SDRAM/cache) and the peripherals block.
- Latches each CPU request and routes it by address[31]: 0 goes to mmu, 1 goes to peripherals.
- Waits for the selected target's valid, then returns registered read data and a one-cycle completion pulse to the CPU.
- Adds a per-request timeout and a misalignment check. Either one raises a sticky bus error that drives the board crash LED.

---
 rtl/bus_router.sv | 146 ++++++++++++++
 tb/tb_bus_router.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_router.sv
// Registered bus stage between the CPU memory port and its two targets (mmu, peripherals).
// Routes each request by address[31], enforces alignment and a per-request timeout, and raises a sticky bus error.
module bus_router #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic        cpu_rw_req,
    input  logic        cpu_rw,
    input  logic [31:0] cpu_write_data,
    input  logic [1:0]  cpu_size,
    output logic [31:0] cpu_read_data,
    output logic        cpu_rec,
    output logic [31:0] address,
    output logic        rw,
    output logic [31:0] write_data,
    output logic [1:0]  size,
    output logic        mem_rw_req,
    input  logic [31:0] mem_read_data,
    input  logic        mem_valid,
    output logic        per_rw_req,
    input  logic [31:0] per_read_data,
    input  logic        per_valid,
    output logic        bus_err,
    output logic        busy
);

    localparam int unsigned    CW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_PER,
        S_ERR,
        S_RESP,
        S_DROP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   address_q, address_d;
    logic          rw_q, rw_d;
    logic [31:0]   write_data_q, write_data_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          bus_err_q, bus_err_d;

    logic          tgt_valid;
    logic [31:0]   tgt_data;

    // Half-words need bit 0 clear, words need bits 1:0 clear, size 11 is never legal.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    assign tgt_valid = (state_q == S_MEM) ? mem_valid     : per_valid;
    assign tgt_data  = (state_q == S_MEM) ? mem_read_data : per_read_data;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        count_d      = '0;
        address_d    = address_q;
        rw_d         = rw_q;
        write_data_d = write_data_q;
        size_d       = size_q;
        read_data_d  = read_data_q;
        bus_err_d    = bus_err_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_rw_req) begin
                    address_d    = cpu_address;
                    rw_d         = cpu_rw;
                    write_data_d = cpu_write_data;
                    size_d       = cpu_size;
                    if (is_misaligned(cpu_size, cpu_address[1:0])) state_d = S_ERR;
                    else if (cpu_address[31])                      state_d = S_PER;
                    else                                           state_d = S_MEM;
                end
            end
            S_MEM, S_PER: begin
                // Valid is checked first so a response on the last allowed cycle still completes.
                if (tgt_valid) begin
                    read_data_d = tgt_data;
                    state_d     = S_RESP;
                end else if (count_q == CNT_MAX) begin
                    state_d = S_ERR;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_ERR: begin
                read_data_d = ERR_DATA;
                bus_err_d   = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: state_d = S_DROP;
            S_DROP: if (!cpu_rw_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            address_q    <= '0;
            rw_q         <= 1'b0;
            write_data_q <= '0;
            size_q       <= '0;
            read_data_q  <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            address_q    <= address_d;
            rw_q         <= rw_d;
            write_data_q <= write_data_d;
            size_q       <= size_d;
            read_data_q  <= read_data_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign mem_rw_req    = (state_q == S_MEM);
    assign per_rw_req    = (state_q == S_PER);
    assign cpu_rec       = (state_q == S_RESP);
    assign busy          = (state_q != S_IDLE);
    assign cpu_read_data = read_data_q;
    assign address       = address_q;
    assign rw            = rw_q;
    assign write_data    = write_data_q;
    assign size          = size_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_bus_router.sv
// Self-checking bench for bus_router: directed scenarios plus randomized transactions
// compared against a transaction-level model of routing, alignment and timeout rules.
module tb_bus_router;

    localparam int          T       = 16;
    localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_address;
    logic        cpu_rw_req;
    logic        cpu_rw;
    logic [31:0] cpu_write_data;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_read_data;
    logic        cpu_rec;
    logic [31:0] address;
    logic        rw;
    logic [31:0] write_data;
    logic [1:0]  size;
    logic        mem_rw_req;
    logic [31:0] mem_read_data;
    logic        mem_valid;
    logic        per_rw_req;
    logic [31:0] per_read_data;
    logic        per_valid;
    logic        bus_err;
    logic        busy;

    bus_router #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR_VAL)) dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_rw_req(cpu_rw_req), .cpu_rw(cpu_rw),
        .cpu_write_data(cpu_write_data), .cpu_size(cpu_size),
        .cpu_read_data(cpu_read_data), .cpu_rec(cpu_rec),
        .address(address), .rw(rw), .write_data(write_data), .size(size),
        .mem_rw_req(mem_rw_req), .mem_read_data(mem_read_data), .mem_valid(mem_valid),
        .per_rw_req(per_rw_req), .per_read_data(per_read_data), .per_valid(per_valid),
        .bus_err(bus_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit err_sticky = 1'b0;

    typedef struct {
        int          mem_cyc;
        int          per_cyc;
        logic [31:0] data;
        bit          err;
    } exp_t;

    // Observations collected by run_txn for one transaction.
    int          obs_mem, obs_per, obs_rec, obs_both;
    logic [31:0] obs_data, obs_addr, obs_wdata;
    logic        obs_rw;
    logic [1:0]  obs_size;
    bit          obs_done;

    // Transaction-level reference: what the CPU should see for a request.
    function automatic exp_t model(input logic [31:0] a, input logic [1:0] sz,
                                   input int lat, input logic [31:0] rd);
        exp_t e;
        bit   mis;
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        e.mem_cyc = 0;
        e.per_cyc = 0;
        if (mis) begin
            e.data = ERR_VAL;
            e.err  = 1'b1;
        end else begin
            int cyc;
            cyc    = (lat <= T) ? lat : T;
            e.data = (lat <= T) ? rd : ERR_VAL;
            e.err  = (lat > T);
            if (a[31]) e.per_cyc = cyc;
            else       e.mem_cyc = cyc;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_rw_req = 1'b0;
        mem_valid = 1'b0;
        per_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        err_sticky = 1'b0;
    endtask

    // Drives one CPU request, plays the selected target with the given latency
    // (valid on the lat-th request cycle), holds the request `hold` cycles after cpu_rec.
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [1:0] sz, input int lat, input logic [31:0] rd,
                           input int hold);
        int seen;
        int hold_left;
        bit rec_seen;
        bit first_busy;
        obs_mem = 0; obs_per = 0; obs_rec = 0; obs_both = 0; obs_done = 1'b0;
        obs_data = '0; obs_addr = '0; obs_wdata = '0; obs_rw = 1'b0; obs_size = '0;
        seen = 0; hold_left = hold; rec_seen = 1'b0; first_busy = 1'b1;
        cpu_address = a; cpu_rw = w; cpu_write_data = wd; cpu_size = sz; cpu_rw_req = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            mem_valid = 1'b0;
            per_valid = 1'b0;
            if (busy && first_busy) begin
                first_busy = 1'b0;
                obs_addr = address; obs_rw = rw; obs_wdata = write_data; obs_size = size;
            end
            if (mem_rw_req && per_rw_req) obs_both++;
            if (mem_rw_req || per_rw_req) begin
                if (mem_rw_req) obs_mem++;
                else            obs_per++;
                seen++;
                if (seen == lat) begin
                    if (mem_rw_req) begin mem_valid = 1'b1; mem_read_data = rd; end
                    else            begin per_valid = 1'b1; per_read_data = rd; end
                end
            end else begin
                // Stray target strobes while nothing is requested must be ignored.
                mem_valid = 1'($urandom);
                per_valid = 1'($urandom);
                mem_read_data = $urandom;
                per_read_data = $urandom;
            end
            if (cpu_rec) begin
                obs_rec++;
                obs_data = cpu_read_data;
                rec_seen = 1'b1;
            end
            if (rec_seen && !busy && !cpu_rw_req) begin
                obs_done = 1'b1;
                break;
            end
            if (rec_seen && cpu_rw_req) begin
                if (hold_left == 0) cpu_rw_req = 1'b0;
                else                hold_left--;
            end
        end
        mem_valid = 1'b0;
        per_valid = 1'b0;
        if (!obs_done) begin
            $display("FAIL txn_budget addr=%h: transaction did not complete within 400 cycles", a);
            do_reset();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_rw_req = 1'b0; cpu_address = '0; cpu_rw = 1'b0; cpu_write_data = '0; cpu_size = '0;
        mem_valid = 1'b0; per_valid = 1'b0; mem_read_data = '0; per_read_data = '0;
        step(); step(); step();
        reset = 1'b0;
        checks++; if ({cpu_rec, mem_rw_req, per_rw_req, busy, bus_err, rw} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000", {cpu_rec, mem_rw_req, per_rw_req, busy, bus_err, rw});
        end
        checks++; if (address !== 32'h0 || write_data !== 32'h0 || size !== 2'b0) begin
            failures++; $display("FAIL reset_latches got addr=%h wd=%h size=%b exp=0", address, write_data, size);
        end
        checks++; if (cpu_read_data !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got=%h exp=0", cpu_read_data);
        end
    endtask

    task automatic test_word_read();
        exp_t e;
        e = model(32'h0000_0100, 2'b10, 3, 32'h1234_5678);
        run_txn(32'h0000_0100, 1'b0, 32'h0, 2'b10, 3, 32'h1234_5678, 0);
        checks++; if (obs_mem !== e.mem_cyc || obs_mem !== 3) begin
            failures++; $display("FAIL word_read mem_req_cycles got=%0d exp=%0d", obs_mem, e.mem_cyc);
        end
        checks++; if (obs_per !== 0 || obs_both !== 0) begin
            failures++; $display("FAIL word_read per_req got per=%0d both=%0d exp=0", obs_per, obs_both);
        end
        checks++; if (obs_rec !== 1 || obs_data !== 32'h1234_5678) begin
            failures++; $display("FAIL word_read rec got pulses=%0d data=%h exp=1 data=12345678", obs_rec, obs_data);
        end
        checks++; if (bus_err !== 1'b0) begin
            failures++; $display("FAIL word_read bus_err got=%b exp=0", bus_err);
        end
        checks++; if (cpu_read_data !== 32'h1234_5678) begin
            failures++; $display("FAIL word_read rdata_hold got=%h exp=12345678", cpu_read_data);
        end
    endtask

    task automatic test_byte_write();
        run_txn(32'h8000_0004, 1'b1, 32'h0000_00A5, 2'b00, 1, 32'h0, 0);
        checks++; if (obs_addr !== 32'h8000_0004 || obs_rw !== 1'b1 || obs_size !== 2'b00 || obs_wdata !== 32'h0000_00A5) begin
            failures++; $display("FAIL byte_write latched got addr=%h rw=%b size=%b wd=%h exp addr=80000004 rw=1 size=00 wd=000000a5",
                                 obs_addr, obs_rw, obs_size, obs_wdata);
        end
        checks++; if (obs_per !== 1 || obs_mem !== 0) begin
            failures++; $display("FAIL byte_write req_cycles got per=%0d mem=%0d exp per=1 mem=0", obs_per, obs_mem);
        end
        checks++; if (obs_rec !== 1) begin
            failures++; $display("FAIL byte_write rec_pulses got=%0d exp=1", obs_rec);
        end
    endtask

    task automatic test_misaligned();
        run_txn(32'h0000_0102, 1'b0, 32'h0, 2'b10, 1, 32'h5555_5555, 0);
        err_sticky = 1'b1;
        checks++; if (obs_mem !== 0 || obs_per !== 0) begin
            failures++; $display("FAIL misaligned req_cycles got mem=%0d per=%0d exp=0", obs_mem, obs_per);
        end
        checks++; if (obs_rec !== 1 || obs_data !== ERR_VAL) begin
            failures++; $display("FAIL misaligned rec got pulses=%0d data=%h exp=1 data=deadbeef", obs_rec, obs_data);
        end
        checks++; if (bus_err !== 1'b1) begin
            failures++; $display("FAIL misaligned bus_err got=%b exp=1", bus_err);
        end
        // A clean transaction afterwards must leave the error flag set.
        run_txn(32'h0000_0200, 1'b0, 32'h0, 2'b01, 2, 32'hCAFE_0001, 0);
        checks++; if (bus_err !== 1'b1 || obs_data !== 32'hCAFE_0001) begin
            failures++; $display("FAIL misaligned sticky got bus_err=%b data=%h exp bus_err=1 data=cafe0001", bus_err, obs_data);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run_txn(32'h8000_0010, 1'b0, 32'h0, 2'b10, 1000, 32'h0, 0);
        checks++; if (obs_per !== T || obs_mem !== 0) begin
            failures++; $display("FAIL timeout per_req_cycles got=%0d mem=%0d exp=%0d mem=0", obs_per, obs_mem, T);
        end
        checks++; if (obs_rec !== 1 || obs_data !== ERR_VAL || bus_err !== 1'b1) begin
            failures++; $display("FAIL timeout result got pulses=%0d data=%h err=%b exp=1 deadbeef 1", obs_rec, obs_data, bus_err);
        end
        // Valid on the last allowed cycle beats the timeout.
        do_reset();
        run_txn(32'h0000_0020, 1'b0, 32'h0, 2'b10, T, 32'hAAAA_5555, 0);
        checks++; if (obs_mem !== T || obs_data !== 32'hAAAA_5555 || bus_err !== 1'b0) begin
            failures++; $display("FAIL valid_wins got cycles=%0d data=%h err=%b exp=%0d aaaa5555 0", obs_mem, obs_data, bus_err, T);
        end
    endtask

    task automatic test_hold_drop();
        run_txn(32'h0000_0040, 1'b0, 32'h0, 2'b10, 2, 32'h0BAD_F00D, 5);
        checks++; if (obs_mem !== 2 || obs_rec !== 1) begin
            failures++; $display("FAIL hold_drop got mem_cycles=%0d pulses=%0d exp 2 1", obs_mem, obs_rec);
        end
        run_txn(32'h8000_0044, 1'b0, 32'h0, 2'b10, 4, 32'h1357_9BDF, 0);
        checks++; if (obs_per !== 4 || obs_rec !== 1 || obs_data !== 32'h1357_9BDF) begin
            failures++; $display("FAIL hold_next got per_cycles=%0d pulses=%0d data=%h exp 4 1 13579bdf", obs_per, obs_rec, obs_data);
        end
    endtask

    task automatic test_reset_mid_mem();
        int seen;
        int rec_cnt;
        seen = 0;
        run_txn(32'h0000_0080, 1'b0, 32'h0, 2'b11, 1, 32'h0, 0);
        err_sticky = 1'b1;
        cpu_address = 32'h0000_0300; cpu_rw = 1'b0; cpu_size = 2'b10; cpu_rw_req = 1'b1;
        for (int i = 0; i < 20 && seen < 3; i++) begin
            step();
            if (mem_rw_req) seen++;
        end
        checks++; if (seen !== 3) begin
            failures++; $display("FAIL reset_mid_mem reach_mem got=%0d exp=3", seen);
        end
        reset = 1'b1;
        cpu_rw_req = 1'b0;
        step();
        checks++; if (mem_rw_req !== 1'b0 || busy !== 1'b0 || bus_err !== 1'b0 || cpu_rec !== 1'b0) begin
            failures++; $display("FAIL reset_mid_mem after got req=%b busy=%b err=%b rec=%b exp 0000",
                                 mem_rw_req, busy, bus_err, cpu_rec);
        end
        reset = 1'b0;
        err_sticky = 1'b0;
        rec_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_rec) rec_cnt++;
        end
        checks++; if (rec_cnt !== 0) begin
            failures++; $display("FAIL reset_mid_mem late_rec got=%0d exp=0", rec_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, wd, rd;
            logic [1:0]  sz;
            logic        w;
            int          lat, hold;
            exp_t        e;
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            sz   = 2'($urandom);
            w    = 1'($urandom);
            wd   = $urandom;
            rd   = $urandom;
            lat  = $urandom_range(1, T + 3);
            hold = $urandom_range(0, 3);
            e = model(a, sz, lat, rd);
            run_txn(a, w, wd, sz, lat, rd, hold);
            err_sticky = err_sticky | e.err;
            checks++; if (obs_mem !== e.mem_cyc || obs_per !== e.per_cyc || obs_both !== 0) begin
                failures++; $display("FAIL random[%0d] req_cycles got mem=%0d per=%0d both=%0d exp mem=%0d per=%0d",
                                     n, obs_mem, obs_per, obs_both, e.mem_cyc, e.per_cyc);
            end
            checks++; if (obs_rec !== 1 || obs_data !== e.data) begin
                failures++; $display("FAIL random[%0d] rec got pulses=%0d data=%h exp 1 data=%h", n, obs_rec, obs_data, e.data);
            end
            checks++; if (obs_addr !== a || obs_rw !== w || obs_wdata !== wd || obs_size !== sz) begin
                failures++; $display("FAIL random[%0d] latched got %h %b %h %b exp %h %b %h %b",
                                     n, obs_addr, obs_rw, obs_wdata, obs_size, a, w, wd, sz);
            end
            checks++; if (bus_err !== err_sticky) begin
                failures++; $display("FAIL random[%0d] bus_err got=%b exp=%b", n, bus_err, err_sticky);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write();
        test_misaligned();
        test_timeout();
        do_reset();
        test_hold_drop();
        test_reset_mid_mem();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
